// File: rtl/vp_pkg.sv
// Shared types for the vector-processor command sequencer: opcodes, register
// selects, program-word layout, fault codes and FSM encoding.
package vp_pkg;

  localparam int unsigned WORD_W  = 14;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned CODE_W  = 2;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    A1 = 2'b00,
    A2 = 2'b01,
    A3 = 2'b10,
    A4 = 2'b11
  } reg_e;

  // Program word: {halt[13], instr[12:11], reg_sel[10:9], mem_addr[8:0]}
  typedef struct packed {
    logic              halt;
    op_e               instr;
    reg_e              reg_sel;
    logic [ADDR_W-1:0] mem_addr;
  } prog_word_t;

  localparam logic [CODE_W-1:0] FC_NONE  = 2'b00;
  localparam logic [CODE_W-1:0] FC_BOUND = 2'b01;
  localparam logic [CODE_W-1:0] FC_PROC  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_CHECKB = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  function automatic logic is_mem_op(input op_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/vp_sequencer_if.sv
// Command bus between the sequencer (master) and the vector processor (slave).
interface vp_sequencer_if;
  import vp_pkg::*;

  op_e               instruction;
  logic [ADDR_W-1:0] mem_addr;
  reg_e              reg_select;
  logic              issue_valid;
  logic              out_of_bound;

  modport master (
    output instruction,
    output mem_addr,
    output reg_select,
    output issue_valid,
    input  out_of_bound
  );

  modport slave (
    input  instruction,
    input  mem_addr,
    input  reg_select,
    input  issue_valid,
    output out_of_bound
  );

endinterface

// File: rtl/vp_prog_ram.sv
// Program store: single write port, registered read port, contents not reset.
module vp_prog_ram
  import vp_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vp_sequencer.sv
// Replays a stored vector-op program onto the processor command port, one op
// every four cycles, with a local bound pre-check and first-fault stop.
module vp_sequencer
  import vp_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned LANES      = 16,
  localparam int unsigned PC_W      = $clog2(PROG_DEPTH),
  localparam int unsigned CNT_W     = PC_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [WORD_W-1:0]   prog_data,
  input  logic                start,
  input  logic                abort,
  vp_sequencer_if.master      cmd,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [CODE_W-1:0]   fault_code,
  output logic [PC_W-1:0]     fault_pc,
  output logic [CNT_W-1:0]    ops_issued
);

  localparam int unsigned BOUND_MAX = MEM_DEPTH - LANES;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic              abort_q;
  op_e               instr_q;
  logic [ADDR_W-1:0] addr_q;
  reg_e              reg_q;
  logic              issue_q;
  logic              busy_q;
  logic              done_q;
  logic              fault_q;
  logic [CODE_W-1:0] code_q;
  logic [PC_W-1:0]   fpc_q;
  logic [CNT_W-1:0]  ops_q;

  logic [WORD_W-1:0] ram_rdata;
  prog_word_t        word_c;
  logic              accepting_c;
  logic              abort_seen_c;
  logic              bound_fault_c;

  assign accepting_c   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT);
  assign abort_seen_c  = abort || abort_q;
  assign word_c        = prog_word_t'(ram_rdata);
  assign bound_fault_c = is_mem_op(word_c.instr) && (32'(word_c.mem_addr) > BOUND_MAX);

  vp_prog_ram #(
    .DEPTH (PROG_DEPTH)
  ) u_prog_ram (
    .clk     (clk),
    .we_i    (prog_we && accepting_c),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (ram_rdata)
  );

  // Sequencer FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      abort_q <= 1'b0;
      instr_q <= OP_LOAD;
      addr_q  <= '0;
      reg_q   <= A1;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      fpc_q   <= '0;
      ops_q   <= '0;
    end else begin
      issue_q <= 1'b0;
      if (!accepting_c && abort) begin
        abort_q <= 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            pc_q    <= '0;
            ops_q   <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (abort_seen_c) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_CHECKB;
          end
        end

        S_CHECKB: begin
          if (abort_seen_c || word_c.halt) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (bound_fault_c) begin
            fault_q <= 1'b1;
            code_q  <= FC_BOUND;
            fpc_q   <= pc_q;
            busy_q  <= 1'b0;
            state_q <= S_FAULT;
          end else begin
            instr_q <= word_c.instr;
            addr_q  <= word_c.mem_addr;
            reg_q   <= word_c.reg_sel;
            issue_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state_q <= S_WAIT;
        end

        // Processor fault outranks a pending abort.
        S_WAIT: begin
          if (cmd.out_of_bound) begin
            fault_q <= 1'b1;
            code_q  <= FC_PROC;
            fpc_q   <= pc_q;
            busy_q  <= 1'b0;
            state_q <= S_FAULT;
          end else begin
            ops_q <= ops_q + CNT_W'(1);
            if (abort_seen_c || (pc_q == LAST_PC)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_q + PC_W'(1);
              state_q <= S_FETCH;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd.instruction = instr_q;
  assign cmd.mem_addr    = addr_q;
  assign cmd.reg_select  = reg_q;
  assign cmd.issue_valid = issue_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fault           = fault_q;
  assign fault_code      = code_q;
  assign fault_pc        = fpc_q;
  assign ops_issued      = ops_q;

endmodule

// File: doc/vp_sequencer.md
Name: vp_sequencer

Overview:
- Command initiator for the vector processor's instruction interface. It drives instruction, mem_addr and reg_select, and watches out_of_bound.
- Replays a small program of vector ops (load / store / add / multiply) from an internal program RAM, one op at a time.
- Pre-checks memory bounds locally, stops on the first fault, and reports status.
- Replaces hand-driven stimulus at the processor's command port; sits between host/control logic and VectorProcessor.

Parameters:
- PROG_DEPTH, 32, number of program words; power of two.
- MEM_DEPTH, 512, processor data-memory depth in 32-bit words.
- LANES, 16, words moved per load/store (512-bit vector / 32).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  $clog2(PROG_DEPTH)  program write address.
- prog_data  in  14  program word {halt[13], instr[12:11], reg_sel[10:9], mem_addr[8:0]}.
- start  in  1  one-cycle pulse; begins execution at pc=0.
- abort  in  1  stop after the current op completes.
- instruction  out  2  to processor: 00 load, 01 store, 10 add, 11 multiply.
- mem_addr  out  9  to processor.
- reg_select  out  2  to processor.
- issue_valid  out  1  high during the ISSUE cycle only.
- out_of_bound  in  1  from processor; registered, valid the cycle after issue.
- busy  out  1  high outside IDLE/DONE/FAULT.
- done  out  1  level; high in DONE.
- fault  out  1  level; high in FAULT.
- fault_code  out  2  00 none, 01 local bound pre-check, 10 processor-reported.
- fault_pc  out  $clog2(PROG_DEPTH)  pc of the faulting op.
- ops_issued  out  $clog2(PROG_DEPTH)+1  count of ops completed without fault.

Behaviour:
- Reset value of all outputs is 0: instruction=00, mem_addr=0, reg_select=0, issue_valid=0, busy=0, done=0, fault=0, fault_code=00, fault_pc=0, ops_issued=0. pc=0, state=IDLE.
- Program RAM contents are not reset.
- Program writes:
  - accepted only in IDLE, DONE or FAULT;
  - ignored in all other states.
- FSM states: IDLE, FETCH, CHECKB, ISSUE, WAIT, DONE, FAULT.
- IDLE/DONE/FAULT + start: pc<=0, ops_issued<=0, clear done/fault/fault_code, go to FETCH. start is ignored in every other state.
- FETCH: synchronous RAM read of word[pc]; go to CHECKB.
- CHECKB:
  - halt=1 -> DONE, nothing issued.
  - Load or store with mem_addr > MEM_DEPTH-LANES (496 by default) -> FAULT, fault_code=01, fault_pc=pc, nothing issued.
  - Otherwise -> ISSUE.
- ISSUE:
  - Register instruction/mem_addr/reg_select from the fetched word; issue_valid=1 for exactly this cycle.
  - The command fields stay stable until the next ISSUE.
  - Go to WAIT.
- WAIT: sample out_of_bound.
  - 1 -> FAULT, fault_code=10, fault_pc=pc.
  - 0 -> ops_issued++. Then, in order of priority:
    - abort seen since start -> DONE;
    - pc==PROG_DEPTH-1 -> DONE;
    - else pc++ and go to FETCH.
- Issue rate: one op per 4 cycles.
- abort:
  - Latched when asserted in any busy state.
  - Never cuts off an op already in ISSUE/WAIT.
  - Asserted in FETCH/CHECKB: go to DONE at the next transition without issuing.
- Simultaneous abort and processor fault in WAIT: FAULT wins.
- Command outputs hold their last values in DONE/FAULT. Every op type is idempotent on the processor, so repeated edges are harmless.
- rst mid-operation: immediate return to reset values at the next edge. A partially issued op is abandoned.
- add/multiply never fail the pre-check; their mem_addr field is ignored.

Decomposition:
- Shared package vp_pkg:
  - opcode constants OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_MUL=2'b11;
  - register selects A1=00, A2=01, A3=10, A4=11;
  - program-word field positions;
  - fault_code constants;
  - FSM state encoding.
- One sub-module, vp_prog_ram: PROG_DEPTH x 14 single-port-write / registered-read RAM.

Test Plan:
- Program [load 0->A1, load 16->A2, add, mul, halt]; start -> four issue_valid pulses 4 cycles apart with instruction 00,00,10,11; done=1; ops_issued=4; fault=0.
- Word0 = load addr 500; start -> no issue_valid; fault=1, fault_code=01, fault_pc=0 within 3 cycles.
- Word0 = store addr 496, with a processor model asserting out_of_bound -> one issue_valid; then fault=1, fault_code=10, fault_pc=0, ops_issued=0.
- Assert abort during the ISSUE cycle of op 1 in a 5-op program -> op 1 completes, ops_issued=2, done=1, op 2 never issued.
- prog_we pulses while busy, then halt is reached -> the program RAM word read back is unchanged. rst asserted in WAIT -> all outputs 0 next cycle, state IDLE.
- All PROG_DEPTH words non-halt add ops -> exactly 32 issues; done=1 after pc=31; pc does not wrap.
